// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the stages that follow it.
//
// Contents:
//   OP_*          3-bit ALU operation select encodings
//   alu_entry_t   14-bit captured result record: {sel, result, carry, zero, divz}
//   is_div_by_zero  helper that tags a divide whose B operand is zero
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       divz;
    } alu_entry_t;

    function automatic logic is_div_by_zero(input logic [2:0] sel, input logic [3:0] b);
        return (sel == OP_DIV) && (b == 4'h0);
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake bundle for alu_result_fifo.
//
// Producer side : in_valid, in_ready, in_sel, in_result, in_carry, in_b
// Consumer side : out_valid, out_ready, out_sel, out_result, out_carry,
//                 out_zero, out_divz
// Modports:
//   master - the environment (drives ALU results, consumes head entries)
//   slave  - the FIFO itself
interface alu_result_fifo_if;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic [7:0] in_result;
    logic       in_carry;
    logic [3:0] in_b;

    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sel;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_divz;

    modport master (
        output in_valid, in_sel, in_result, in_carry, in_b, out_ready,
        input  in_ready, out_valid, out_sel, out_result, out_carry, out_zero, out_divz
    );

    modport slave (
        input  in_valid, in_sel, in_result, in_carry, in_b, out_ready,
        output in_ready, out_valid, out_sel, out_result, out_carry, out_zero, out_divz
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for an incoming ALU result.
//
// Ports:
//   in_sel    [2:0]  operation select that produced the result
//   in_result [7:0]  ALU output
//   in_b      [3:0]  B operand (only consulted for divide-by-zero)
//   zero             result is all zeros
//   divz             operation was a divide with B == 0
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [2:0] in_sel,
    input  logic [7:0] in_result,
    input  logic [3:0] in_b,
    output logic       zero,
    output logic       divz
);

    assign zero = (in_result == 8'h00);
    assign divz = is_div_by_zero(in_sel, in_b);

endmodule

// File: rtl/alu_result_fifo.sv
// In-order result FIFO that decouples the combinational ALU from a consumer
// that may stall. Each pushed entry carries the opcode, result, carry and the
// zero/divide-by-zero flags evaluated at push time.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (empties the FIFO immediately)
//   flush  synchronous clear; overrides any push/pop on the same edge
//   bus    alu_result_fifo_if.slave handshake bundle
//   count  occupancy, 0..DEPTH
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_result_fifo_if.slave    bus,
    output logic [AW:0]         count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic          flag_zero;
    logic          flag_divz;
    alu_entry_t    entry_in;
    alu_entry_t    head;

    alu_entry_t    mem [DEPTH];

    alu_flag_gen u_flag_gen (
        .in_sel    (bus.in_sel),
        .in_result (bus.in_result),
        .in_b      (bus.in_b),
        .zero      (flag_zero),
        .divz      (flag_divz)
    );

    // Handshake status comes only from registered occupancy, so a pop in the
    // same cycle never frees a slot for a push while full.
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    assign entry_in = '{sel:    bus.in_sel,
                        result: bus.in_result,
                        carry:  bus.in_carry,
                        zero:   flag_zero,
                        divz:   flag_divz};

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Storage needs no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= entry_in;
        end
    end

    // Head is read asynchronously so a freshly pushed entry is visible right
    // after its push edge.
    assign head = mem[rd_ptr_reg];

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_sel    = head.sel;
    assign bus.out_result = head.result;
    assign bus.out_carry  = head.carry;
    assign bus.out_zero   = head.zero;
    assign bus.out_divz   = head.divz;
    assign count          = count_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;

    int checks;
    int failures;

    alu_result_fifo_if bus ();

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] sel, input logic [7:0] res,
                          input logic c, input logic [3:0] b);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_result = res;
        bus.in_carry  = c;
        bus.in_b      = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("reset: out_valid=%b in_ready=%b count=%0d", bus.out_valid, bus.in_ready, count);
    endtask

    task automatic test_single_push();
        set_in(1'b1, 3'b000, 8'h0C, 1'b0, 4'h7);
        step();
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h0C) begin failures++; $display("FAIL single_result: got %h expected 0c", bus.out_result); end
        checks++; if (bus.out_sel !== 3'b000) begin failures++; $display("FAIL single_sel: got %b expected 000", bus.out_sel); end
        checks++; if (bus.out_zero !== 1'b0 || bus.out_divz !== 1'b0) begin failures++; $display("FAIL single_flags: got zero=%b divz=%b expected 0 0", bus.out_zero, bus.out_divz); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", count); end
        $display("single push: result=%h count=%0d", bus.out_result, count);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_pop: got count=%0d out_valid=%b expected 0 0", count, bus.out_valid); end
        $display("single pop: count=%0d", count);
    endtask

    task automatic test_divz();
        set_in(1'b1, 3'b011, 8'h00, 1'b0, 4'h0);
        step();
        set_in(1'b1, 3'b011, 8'h05, 1'b0, 4'h2);
        step();
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.out_divz !== 1'b1 || bus.out_zero !== 1'b1) begin failures++; $display("FAIL divz_first: got divz=%b zero=%b expected 1 1", bus.out_divz, bus.out_zero); end
        $display("divz entry0: sel=%b divz=%b zero=%b", bus.out_sel, bus.out_divz, bus.out_zero);
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_divz !== 1'b0 || bus.out_zero !== 1'b0 || bus.out_result !== 8'h05) begin failures++; $display("FAIL divz_second: got divz=%b zero=%b result=%h expected 0 0 05", bus.out_divz, bus.out_zero, bus.out_result); end
        $display("divz entry1: sel=%b divz=%b zero=%b", bus.out_sel, bus.out_divz, bus.out_zero);
        step();
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL divz_drain: got count=%0d expected 0", count); end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [2:0] sels [4] = '{3'b100, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, sels[i], vals[i], i[0], 4'h1);
            step();
        end
        checks++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: got count=%0d in_ready=%b expected 4 0", count, bus.in_ready); end
        set_in(1'b1, 3'b000, 8'hAA, 1'b0, 4'h1);
        step();
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_drop: got count=%0d expected 4", count); end
        $display("fill: count=%0d in_ready=%b", count, bus.in_ready);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_result !== vals[i] || bus.out_sel !== sels[i] || bus.out_carry !== i[0]) begin
                failures++;
                $display("FAIL fill_drain%0d: got res=%h sel=%b c=%b expected %h %b %b", i, bus.out_result, bus.out_sel, bus.out_carry, vals[i], sels[i], i[0]);
            end
            $display("drain %0d: result=%h sel=%b", i, bus.out_result, bus.out_sel);
            step();
        end
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty: got count=%0d out_valid=%b expected 0 0", count, bus.out_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'h51 + 8'(i);
            set_in(1'b1, 3'b001, exp_v, 1'b0, 4'h3);
            step();
        end
        set_in(1'b1, 3'b001, 8'hAA, 1'b0, 4'h3);
        bus.out_ready = 1'b1;
        step();
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpop_count: got %0d expected 3", count); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_result !== 8'h52) begin failures++; $display("FAIL fullpop_head: got %h expected 52", bus.out_result); end
        $display("full pop: count=%0d head=%h", count, bus.out_result);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_v = 8'h52 + 8'(i);
            checks++; if (bus.out_result !== exp_v) begin failures++; $display("FAIL fullpop_drain%0d: got %h expected %h", i, bus.out_result, exp_v); end
            step();
        end
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fullpop_empty: got %0d expected 0", count); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_v;
        set_in(1'b1, 3'b010, 8'h60, 1'b1, 4'h4);
        step();
        set_in(1'b1, 3'b010, 8'h61, 1'b1, 4'h4);
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 3'b010, 8'h62 + 8'(i), 1'b1, 4'h4);
            exp_v = 8'h60 + 8'(i);
            checks++; if (bus.out_result !== exp_v) begin failures++; $display("FAIL stream_head%0d: got %h expected %h", i, bus.out_result, exp_v); end
            step();
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL stream_count%0d: got %0d expected 2", i, count); end
            $display("stream %0d: popped=%h count=%0d", i, exp_v, count);
        end
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (bus.out_result !== 8'h6A) begin failures++; $display("FAIL stream_tail0: got %h expected 6a", bus.out_result); end
        step();
        checks++; if (bus.out_result !== 8'h6B) begin failures++; $display("FAIL stream_tail1: got %h expected 6b", bus.out_result); end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'b100, 8'h70 + 8'(i), 1'b0, 4'h1);
            step();
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre: got %0d expected 3", count); end
        set_in(1'b1, 3'b100, 8'hEE, 1'b0, 4'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_clear: got count=%0d out_valid=%b expected 0 0", count, bus.out_valid); end
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_nostore: got %0d expected 0", count); end
        $display("flush: count=%0d out_valid=%b", count, bus.out_valid);
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 3'b101, 8'h81, 1'b0, 4'h1);
        step();
        set_in(1'b1, 3'b101, 8'h82, 1'b0, 4'h1);
        step();
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 4'h0);
        checks++; if (count !== 3'd2 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre: got count=%0d out_valid=%b expected 2 1", count, bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL areset_immediate: got out_valid=%b count=%0d in_ready=%b expected 0 0 1", bus.out_valid, count, bus.in_ready); end
        $display("async reset: out_valid=%b count=%0d", bus.out_valid, count);
        step();
        rst_n = 1'b1;
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL areset_post: got %0d expected 0", count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_push();
        test_divz();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 4-bit combinational ALU: each cycle's ALU result is captured together with its opcode and derived status flags.
- Captured results are held in a small in-order FIFO and presented to the consumer (writeback/display logic) over a valid/ready interface.
- The ALU's purely combinational output is decoupled from a consumer that may stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_sel  input  3  ALU operation select that produced the result.
- in_result  input  8  ALU 8-bit output.
- in_carry  input  1  ALU carry flag.
- in_b  input  4  B operand, used only for the divide-by-zero flag.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer accepts head entry.
- out_sel  output  3  opcode of head entry.
- out_result  output  8  result of head entry.
- out_carry  output  1  carry of head entry.
- out_zero  output  1  head result == 8'h00.
- out_divz  output  1  head entry was a divide with B == 0.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, out_valid = 0, in_ready = 1.
  - Storage contents are don't-care.
  - All out_* data ports drive the stored value at rd_ptr and are don't-care while out_valid = 0.
- Push: occurs when in_valid && in_ready at a rising edge.
  - The entry {in_sel, in_result, in_carry, zero, divz} is written at wr_ptr, and wr_ptr increments.
  - zero = (in_result == 8'h00).
  - divz = (in_sel == 3'b011) && (in_b == 4'h0).
  - Flags are computed at push time, not at pop.
- Pop: occurs when out_valid && out_ready at a rising edge; rd_ptr increments.
- Pointers wrap from DEPTH-1 to 0 naturally at AW bits.
- count update on simultaneous push and pop is +1 - 1 = unchanged.
- Latency: an entry pushed at edge N is visible on out_* with out_valid = 1 after edge N. There is no same-cycle bypass.
- Full (count == DEPTH):
  - in_ready = 0 and pushes are ignored.
  - A pop in the same cycle does NOT enable a push. in_ready has no combinational path from out_ready.
- Empty (count == 0): out_valid = 0 and out_ready is ignored.
- Simultaneous push and pop, 0 < count < DEPTH: both occur and count is unchanged.
- flush: the next edge sets wr_ptr = rd_ptr = count = 0. flush has priority over any push or pop that cycle, and those pushes and pops are discarded.
- Reset mid-operation: all entries are lost immediately (asynchronous). Outputs take their reset values without waiting for a clock.
- in_ready and out_valid are registered-state-derived only: decoded from count, with no input-to-output combinational paths.
- The opcode value is not validated. All 8 encodings are stored as-is.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams: OP_ADD = 3'b000, OP_SUB, OP_MUL, OP_DIV = 3'b011, OP_AND, OP_OR, OP_NAND, OP_XOR.
  - Packed struct alu_entry_t {sel[2:0], result[7:0], carry, zero, divz}, 14 bits.
  - Used by this block and by future ALU-adjacent stages.
- One natural sub-module: alu_flag_gen, combinational, producing zero and divz from in_sel, in_result and in_b. The storage array and pointer logic stay inline.

Test Plan:
- Reset then single push: in_sel = 000, in_result = 8'h0C, in_carry = 0, in_b = 4'h7 → after one edge out_valid = 1, out_result = 8'h0C, out_zero = 0, out_divz = 0, count = 1.
- Divide-by-zero tag: push in_sel = 011, in_result = 8'h00, in_b = 0 → out_divz = 1, out_zero = 1; a second push with in_sel = 011, in_b = 2 → out_divz = 0 for that entry.
- Fill to full: 4 pushes with out_ready = 0 → count = 4, in_ready = 0.
  - A 5th push with result 8'hAA is dropped.
  - Draining yields exactly the 4 values in push order.
- Full with simultaneous in_valid and out_ready: one pop, no push.
  - count goes 4 → 3, then in_ready = 1 next cycle.
  - The popped entry is the oldest.
- Streaming at count = 2 with in_valid = out_ready = 1 for 10 cycles: count stays 2.
  - The output order matches input order across pointer wrap-around.
- flush with in_valid = 1 at count = 3: count = 0 and out_valid = 0 next cycle, and the flushing-cycle input is not stored.
  - Separately, assert rst_n = 0 mid-stream → out_valid drops without a clock edge.
